branch_resolve_unit: RTL and testbench

Pipelined, parametrised branch resolution stage for the pipelined RV32I core. It evaluates all six RISC-V conditional branches from funct3 on XLEN-bit operands and computes the branch target and the fall-through PC. It flags mispredictions against the front-end prediction and keeps saturating branch and mispredict statistics. It sits between decode/register-read and the PC-redirect logic, with a two-stage valid/ready pipeline and flush support.

---
 rtl/branch_resolve_unit.sv | 158 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates RV32I conditional branches, computes the
// target and fall-through PCs, flags mispredictions and keeps saturating
// statistics. Two-stage valid/ready pipeline with synchronous flush.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [PC_W-1:0]  in_imm,
  input  logic             in_pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_eq,
  output logic             out_lt,
  output logic [PC_W-1:0]  out_target,
  output logic [PC_W-1:0]  out_next_pc,
  output logic             out_mispredict,
  output logic             out_misalign,
  output logic             out_illegal,
  output logic [CNT_W-1:0] cnt_branches,
  output logic [CNT_W-1:0] cnt_mispredicts
);

  // Stage 1 registers: raw operands of the branch being evaluated
  logic            s1_valid;
  logic [2:0]      s1_funct3;
  logic [XLEN-1:0] s1_rs1;
  logic [XLEN-1:0] s1_rs2;
  logic [PC_W-1:0] s1_pc;
  logic [PC_W-1:0] s1_imm;
  logic            s1_pred;

  // Combinational results derived from stage 1
  logic            eq;
  logic            slt;
  logic            ult;
  logic            cond;
  logic            illegal;
  logic            lt_sel;
  logic            mispredict;
  logic            misalign;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] fall_through;
  logic [PC_W-1:0] next_pc;

  // Handshake helpers
  logic s2_accept;
  logic in_fire;
  logic s1_move;
  logic out_fire;

  assign s2_accept = !out_valid || out_ready;
  assign in_ready  = !flush && (!s1_valid || s2_accept);
  assign in_fire   = in_valid && in_ready;
  assign s1_move   = s1_valid && s2_accept && !flush;
  assign out_fire  = out_valid && out_ready && !flush;

  assign eq           = (s1_rs1 == s1_rs2);
  assign ult          = (s1_rs1 < s1_rs2);
  assign slt          = ($signed(s1_rs1) < $signed(s1_rs2));
  assign lt_sel       = s1_funct3[1] ? ult : slt;
  assign target       = s1_pc + s1_imm;
  assign fall_through = s1_pc + PC_W'(4);
  assign next_pc      = cond ? target : fall_through;
  assign mispredict   = !illegal && (cond != s1_pred);
  assign misalign     = cond && (target[1:0] != 2'b00);

  // Decode funct3 into the branch condition; the two unused encodings are illegal and never taken
  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (s1_funct3)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = slt;
      3'b101:  cond = !slt;
      3'b110:  cond = ult;
      3'b111:  cond = !ult;
      default: illegal = 1'b1;
    endcase
  end

  // Stage 1 capture: load on input accept, empty when the entry moves on or on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_funct3 <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_pc     <= '0;
      s1_imm    <= '0;
      s1_pred   <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_valid  <= 1'b1;
      s1_funct3 <= in_funct3;
      s1_rs1    <= in_rs1;
      s1_rs2    <= in_rs2;
      s1_pc     <= in_pc;
      s1_imm    <= in_imm;
      s1_pred   <= in_pred_taken;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 result registers drive the outputs directly; payload only changes on a new entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_eq         <= 1'b0;
      out_lt         <= 1'b0;
      out_target     <= '0;
      out_next_pc    <= '0;
      out_mispredict <= 1'b0;
      out_misalign   <= 1'b0;
      out_illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s1_move) begin
      out_valid      <= 1'b1;
      out_taken      <= cond;
      out_eq         <= eq;
      out_lt         <= lt_sel;
      out_target     <= target;
      out_next_pc    <= next_pc;
      out_mispredict <= mispredict;
      out_misalign   <= misalign;
      out_illegal    <= illegal;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating statistics, counted on each consumed legal branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_branches    <= '0;
      cnt_mispredicts <= '0;
    end else if (out_fire && !out_illegal) begin
      if (cnt_branches != '1) cnt_branches <= cnt_branches + CNT_W'(1);
      if (out_mispredict && (cnt_mispredicts != '1)) cnt_mispredicts <= cnt_mispredicts + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenario tasks plus a
// scoreboard monitor that checks every consumed result and the counters.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic        in_pred_taken;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, out_taken, out_eq, out_lt;
  logic [31:0] out_target, out_next_pc;
  logic        out_mispredict, out_misalign, out_illegal;
  logic [15:0] cnt_branches, cnt_mispredicts;

  logic        in_ready4, out_valid4, out_taken4, out_eq4, out_lt4;
  logic [31:0] out_target4, out_next_pc4;
  logic        out_mispredict4, out_misalign4, out_illegal4;
  logic [3:0]  cnt_b4, cnt_m4;

  typedef struct packed {
    logic        taken;
    logic        eq;
    logic        lt;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        mispredict;
    logic        misalign;
    logic        illegal;
  } res_t;

  res_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          pops = 0;
  logic [15:0] exp_br = '0;
  logic [15:0] exp_mp = '0;
  logic [3:0]  exp_br4 = '0;
  logic [3:0]  exp_mp4 = '0;

  branch_resolve_unit #(.XLEN(32), .PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
    .in_imm(in_imm), .in_pred_taken(in_pred_taken), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_eq(out_eq), .out_lt(out_lt), .out_target(out_target),
    .out_next_pc(out_next_pc), .out_mispredict(out_mispredict),
    .out_misalign(out_misalign), .out_illegal(out_illegal),
    .cnt_branches(cnt_branches), .cnt_mispredicts(cnt_mispredicts)
  );

  branch_resolve_unit #(.XLEN(32), .PC_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
    .in_imm(in_imm), .in_pred_taken(in_pred_taken), .flush(flush),
    .out_valid(out_valid4), .out_ready(out_ready), .out_taken(out_taken4),
    .out_eq(out_eq4), .out_lt(out_lt4), .out_target(out_target4),
    .out_next_pc(out_next_pc4), .out_mispredict(out_mispredict4),
    .out_misalign(out_misalign4), .out_illegal(out_illegal4),
    .cnt_branches(cnt_b4), .cnt_mispredicts(cnt_m4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour of one branch
  function automatic res_t model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    res_t r;
    r = '0;
    r.eq = (a == b);
    r.lt = f[1] ? (a < b) : ($signed(a) < $signed(b));
    case (f)
      3'd0: r.taken = (a == b);
      3'd1: r.taken = (a != b);
      3'd4: r.taken = ($signed(a) < $signed(b));
      3'd5: r.taken = ($signed(a) >= $signed(b));
      3'd6: r.taken = (a < b);
      3'd7: r.taken = (a >= b);
      default: r.illegal = 1'b1;
    endcase
    r.target     = pc + imm;
    r.next_pc    = r.taken ? r.target : pc + 32'd4;
    r.mispredict = !r.illegal && (r.taken != pred);
    r.misalign   = r.taken && (r.target[1:0] != 2'b00);
    return r;
  endfunction

  // Scoreboard monitor: sampled mid-cycle, looks at what the coming edge will do
  always @(negedge clk) begin
    res_t got;
    res_t want;
    if (!rst_n) begin
      exp_q.delete();
      exp_br = '0; exp_mp = '0; exp_br4 = '0; exp_mp4 = '0;
    end else begin
      total++;
      if (cnt_branches !== exp_br || cnt_mispredicts !== exp_mp) begin
        bad++;
        $display("[TB] FAIL counters16: got br=%0d mp=%0d want br=%0d mp=%0d", cnt_branches, cnt_mispredicts, exp_br, exp_mp);
      end
      total++;
      if (cnt_b4 !== exp_br4 || cnt_m4 !== exp_mp4) begin
        bad++;
        $display("[TB] FAIL counters4: got br=%0d mp=%0d want br=%0d mp=%0d", cnt_b4, cnt_m4, exp_br4, exp_mp4);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          got = {out_taken, out_eq, out_lt, out_target, out_next_pc, out_mispredict, out_misalign, out_illegal};
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL sb_unexpected: got %h want none", got);
          end else begin
            want = exp_q.pop_front();
            pops++;
            if (got !== want) begin
              bad++;
              $display("[TB] FAIL sb_result: got %h want %h", got, want);
            end
            if (!want.illegal) begin
              if (exp_br != 16'hFFFF) exp_br = exp_br + 16'd1;
              if (exp_br4 != 4'hF) exp_br4 = exp_br4 + 4'd1;
              if (want.mispredict) begin
                if (exp_mp != 16'hFFFF) exp_mp = exp_mp + 16'd1;
                if (exp_mp4 != 4'hF) exp_mp4 = exp_mp4 + 4'd1;
              end
            end
          end
        end
        if (in_valid && in_ready)
          exp_q.push_back(model(in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken));
      end
    end
  end

  task automatic drive_in(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    in_funct3 = f; in_rs1 = a; in_rs2 = b; in_pc = pc; in_imm = imm; in_pred_taken = pred;
    in_valid = 1'b1;
  endtask

  // Push one branch through with out_ready low, leaving the result held at the output
  task automatic run_one(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    int wait_cnt;
    out_ready = 1'b0;
    drive_in(f, a, b, pc, imm, pred);
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      @(posedge clk); #1; wait_cnt++;
    end
    total++;
    if (!in_ready) begin bad++; $display("[TB] FAIL accept_timeout: got in_ready=%b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 20) begin
      @(posedge clk); #1; wait_cnt++;
    end
    total++;
    if (!out_valid) begin bad++; $display("[TB] FAIL result_timeout: got out_valid=%b want 1", out_valid); end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total++;
    if ({out_valid, out_taken, out_eq, out_lt, out_target, out_next_pc, out_mispredict,
         out_misalign, out_illegal, cnt_branches, cnt_mispredicts} !== '0) begin
      bad++; $display("[TB] FAIL reset_outputs: got valid=%b target=%h want all zero", out_valid, out_target);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    flush = 1'b1; #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_flush_ready: got %b want 0", in_ready); end
    flush = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_beq();
    out_ready = 1'b0;
    drive_in(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL beq_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL beq_early: got out_valid=%b want 0", out_valid); end
    @(posedge clk); #1;
    total++;
    if ({out_valid, out_taken, out_eq, out_target, out_next_pc, out_mispredict, out_misalign} !==
        {1'b1, 1'b1, 1'b1, 32'h120, 32'h120, 1'b1, 1'b0}) begin
      bad++; $display("[TB] FAIL beq_result: got v=%b t=%b tgt=%h nxt=%h mp=%b want 1 1 120 120 1",
                      out_valid, out_taken, out_target, out_next_pc, out_mispredict);
    end
    consume();
    total++;
    if (cnt_mispredicts !== 16'd1 || cnt_branches !== 16'd1 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL beq_counters: got br=%0d mp=%0d v=%b want 1 1 0", cnt_branches, cnt_mispredicts, out_valid);
    end
  endtask

  task automatic test_signed_unsigned();
    run_one(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h10, 1'b0);
    total++;
    if (out_taken !== 1'b1 || out_lt !== 1'b1) begin bad++; $display("[TB] FAIL blt: got t=%b lt=%b want 1 1", out_taken, out_lt); end
    consume();
    run_one(3'd6, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h10, 1'b0);
    total++;
    if (out_taken !== 1'b0 || out_lt !== 1'b0) begin bad++; $display("[TB] FAIL bltu: got t=%b lt=%b want 0 0", out_taken, out_lt); end
    consume();
    run_one(3'd7, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h10, 1'b0);
    total++;
    if (out_taken !== 1'b1 || out_next_pc !== 32'h410) begin bad++; $display("[TB] FAIL bgeu: got t=%b nxt=%h want 1 410", out_taken, out_next_pc); end
    consume();
    run_one(3'd5, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h10, 1'b1);
    total++;
    if (out_taken !== 1'b0 || out_next_pc !== 32'h404 || out_mispredict !== 1'b1) begin
      bad++; $display("[TB] FAIL bge: got t=%b nxt=%h mp=%b want 0 404 1", out_taken, out_next_pc, out_mispredict);
    end
    consume();
  endtask

  task automatic test_wrap_misalign();
    run_one(3'd0, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'd8, 1'b1);
    total++;
    if (out_target !== 32'h4 || out_next_pc !== 32'h4 || out_misalign !== 1'b0) begin
      bad++; $display("[TB] FAIL wrap: got tgt=%h nxt=%h mis=%b want 4 4 0", out_target, out_next_pc, out_misalign);
    end
    consume();
    run_one(3'd1, 32'd1, 32'd2, 32'h0, 32'h6, 1'b1);
    total++;
    if (out_taken !== 1'b1 || out_target !== 32'h6 || out_misalign !== 1'b1) begin
      bad++; $display("[TB] FAIL misalign: got t=%b tgt=%h mis=%b want 1 6 1", out_taken, out_target, out_misalign);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [2:0] legal [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    int pops_start;
    pops_start = pops;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_in(legal[$urandom_range(0, 5)], $urandom, $urandom_range(0, 3) == 0 ? 32'd7 : $urandom,
               {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, {$urandom_range(0, 255), 1'b0}, 1'($urandom_range(0, 1)));
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
      if (i >= 2) begin
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_valid%0d: got %b want 1", i, out_valid); end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (pops - pops_start !== 8) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 8", pops - pops_start); end
    out_ready = 1'b0;
    drive_in(3'd0, 32'd1, 32'd1, 32'h200, 32'h40, 1'b1);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL hold_ready0: got %b want 1", in_ready); end
    @(posedge clk); #1;
    drive_in(3'd0, 32'd1, 32'd1, 32'h300, 32'h40, 1'b1);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL hold_ready1: got %b want 1", in_ready); end
    @(posedge clk); #1;
    drive_in(3'd0, 32'd1, 32'd1, 32'h500, 32'h40, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_target !== 32'h240) begin
        bad++; $display("[TB] FAIL hold_cycle%0d: got rdy=%b v=%b tgt=%h want 0 1 240", i, in_ready, out_valid, out_target);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_in(3'd0, 32'd3, 32'd3, 32'h600, 32'h8, 1'b0);
    @(posedge clk); #1;
    drive_in(3'd1, 32'd3, 32'd3, 32'h700, 32'h8, 1'b1);
    @(posedge clk); #1;
    drive_in(3'd0, 32'd4, 32'd4, 32'h800, 32'h8, 1'b0);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || cnt_branches !== exp_br || cnt_mispredicts !== exp_mp) begin
      bad++; $display("[TB] FAIL flush_state: got v=%b br=%0d mp=%0d want 0 %0d %0d", out_valid, cnt_branches, cnt_mispredicts, exp_br, exp_mp);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_no_entry: got %b want 0", out_valid); end
    run_one(3'b010, 32'd7, 32'd7, 32'h900, 32'h8, 1'b1);
    total++;
    if (out_illegal !== 1'b1 || out_taken !== 1'b0 || out_mispredict !== 1'b0 || out_misalign !== 1'b0 || out_next_pc !== 32'h904) begin
      bad++; $display("[TB] FAIL illegal: got ill=%b t=%b mp=%b mis=%b nxt=%h want 1 0 0 0 904",
                      out_illegal, out_taken, out_mispredict, out_misalign, out_next_pc);
    end
    consume();
    total++;
    if (cnt_branches !== exp_br) begin bad++; $display("[TB] FAIL illegal_count: got %0d want %0d", cnt_branches, exp_br); end
  endtask

  task automatic test_saturation();
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_in(3'd0, 32'(i), 32'(i), 32'h1000 + 32'(i * 4), 32'h10, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (cnt_b4 !== 4'hF || cnt_m4 !== 4'hF) begin bad++; $display("[TB] FAIL sat4: got br=%h mp=%h want f f", cnt_b4, cnt_m4); end
    total++;
    if (cnt_branches !== 16'd20 || cnt_mispredicts !== 16'd20) begin
      bad++; $display("[TB] FAIL sat16: got br=%0d mp=%0d want 20 20", cnt_branches, cnt_mispredicts);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_in(3'd1, 32'd1, 32'(i), 32'h2000, 32'h20, 1'b1);
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_taken, out_eq, out_lt, out_target, out_next_pc, out_mispredict,
         out_misalign, out_illegal, cnt_branches, cnt_mispredicts} !== '0 || in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_mid: got v=%b tgt=%h br=%0d rdy=%b want all zero, ready 1",
                      out_valid, out_target, cnt_branches, in_ready);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || cnt_branches !== 16'd0) begin
      bad++; $display("[TB] FAIL reset_mid_after: got v=%b br=%0d want 0 0", out_valid, cnt_branches);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imm = '0;
    in_pred_taken = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    test_reset();
    test_beq();
    test_signed_unsigned();
    test_wrap_misalign();
    test_back_to_back();
    test_flush();
    test_saturation();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
